// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a shift-register RAW scoreboard for the 16-bit 5-stage core.
// Stalls fetch while a source register is still owned by an in-flight writer, since no forwarding path exists.
module if_id_stage #(
  parameter int          SB_DEPTH  = 3,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  input  logic [15:0] PC_incr,
  input  logic        flush,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [2:0]  id_rd,
  input  logic        id_reg_write,
  output logic [15:0] instr_id,
  output logic [15:0] PC_incr_id,
  output logic        valid_id,
  output logic        hazard,
  output logic [15:0] instruction_fb,
  output logic [15:0] PC_added_fb,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e              state_r;
  logic [15:0]         instr_r;
  logic [15:0]         pc_r;
  logic                valid_r;
  logic [15:0]         stall_r;
  logic [SB_DEPTH-1:0] sb_v_r;
  logic [2:0]          sb_rd_r [SB_DEPTH];

  logic rs_match_s;
  logic rt_match_s;
  logic hazard_s;
  logic halt_now_s;

  // Scoreboard lookup, stall request and HALT detection
  always_comb begin
    rs_match_s = 1'b0;
    rt_match_s = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      rs_match_s = rs_match_s | (sb_v_r[i] & (sb_rd_r[i] == id_rs));
      rt_match_s = rt_match_s | (sb_v_r[i] & (sb_rd_r[i] == id_rt));
    end
    hazard_s   = valid_r & (state_r == ST_RUN) &
                 ((id_rs_used & rs_match_s) | (id_rt_used & rt_match_s));
    halt_now_s = valid_r & (instr_r[15:11] == HALT_OPC) & ~flush & ~hazard_s;
  end

  // Pipeline register, scoreboard shift, stall counter and run/halt state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      instr_r <= NOP_INSTR;
      pc_r    <= 16'h0000;
      valid_r <= 1'b0;
      stall_r <= 16'h0000;
      sb_v_r  <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_rd_r[i] <= 3'd0;
      end
    end else begin
      // Older writers always age by one slot; only slot0 depends on the state
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_v_r[i]  <= sb_v_r[i-1];
        sb_rd_r[i] <= sb_rd_r[i-1];
      end
      case (state_r)
        ST_RUN: begin
          if (flush) begin
            instr_r    <= NOP_INSTR;
            pc_r       <= 16'h0000;
            valid_r    <= 1'b0;
            sb_v_r[0]  <= 1'b0;
            sb_rd_r[0] <= 3'd0;
          end else if (hazard_s) begin
            sb_v_r[0]  <= 1'b0;
            sb_rd_r[0] <= 3'd0;
            stall_r    <= (stall_r == 16'hFFFF) ? stall_r : stall_r + 16'd1;
          end else begin
            instr_r    <= instruction;
            pc_r       <= PC_incr;
            valid_r    <= 1'b1;
            sb_v_r[0]  <= valid_r & id_reg_write;
            sb_rd_r[0] <= id_rd;
          end
          state_r <= halt_now_s ? ST_HALT : ST_RUN;
        end
        ST_HALT: begin
          sb_v_r[0]  <= 1'b0;
          sb_rd_r[0] <= 3'd0;
          state_r    <= ST_HALT;
        end
        default: begin
          sb_v_r[0]  <= 1'b0;
          sb_rd_r[0] <= 3'd0;
          state_r    <= ST_RUN;
        end
      endcase
    end
  end

  assign instr_id       = instr_r;
  assign PC_incr_id     = pc_r;
  assign valid_id       = valid_r;
  assign hazard         = hazard_s;
  assign instruction_fb = instr_r;
  assign PC_added_fb    = pc_r;
  assign halted         = (state_r == ST_HALT);
  assign stall_cycles   = stall_r;

endmodule
